// File: rtl/config_loader.sv
// Serial loader for a config tile shift chain: accepts host words, shifts them
// LSB first into the chain, then commits with a single set_hard pulse.
module config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              shift_enable,
  output logic              cfg_bit,
  output logic              set_hard,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SET} state_t;

  localparam int                IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [16:0]       CHAIN_END = 17'(CHAIN_LEN);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wbuf_q, wbuf_d, wbuf_next;
  logic [16:0]       cnt_inc;
  logic              in_ready_q, in_ready_d;
  logic              shift_enable_q, shift_enable_d;
  logic              cfg_bit_q, cfg_bit_d;
  logic              set_hard_q, set_hard_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
  assign wbuf_next = wbuf_q >> 1;

  // Outputs are computed for the state being entered, so each one is a flop.
  // The buffer shifts right so the bit on cfg_bit is always the buffer LSB.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    wbuf_d         = wbuf_q;
    in_ready_d     = 1'b0;
    shift_enable_d = 1'b0;
    cfg_bit_d      = 1'b0;
    set_hard_d     = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          cnt_d      = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (in_valid && in_ready_q) begin
          state_d        = SHIFT;
          wbuf_d         = in_data;
          idx_d          = '0;
          shift_enable_d = 1'b1;
          cfg_bit_d      = in_data[0];
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_inc[15:0];
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_inc == CHAIN_END) begin
          state_d    = SET;
          set_hard_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
        end else begin
          idx_d          = idx_q + 1'b1;
          wbuf_d         = wbuf_next;
          shift_enable_d = 1'b1;
          cfg_bit_d      = wbuf_next[0];
        end
      end
      SET: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      wbuf_q         <= '0;
      in_ready_q     <= 1'b0;
      shift_enable_q <= 1'b0;
      cfg_bit_q      <= 1'b0;
      set_hard_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      wbuf_q         <= wbuf_d;
      in_ready_q     <= in_ready_d;
      shift_enable_q <= shift_enable_d;
      cfg_bit_q      <= cfg_bit_d;
      set_hard_q     <= set_hard_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign shift_enable = shift_enable_q;
  assign cfg_bit      = cfg_bit_q;
  assign set_hard     = set_hard_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: expected chain bits are queued as words are
// offered and popped on every shift_enable cycle.
module tb_config_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, shift_enable, cfg_bit, set_hard, busy, done;

  logic       start1 = 1'b0, abort1 = 1'b0, in_valid1 = 1'b0;
  logic [7:0] in_data1 = 8'h00;
  logic       in_ready1, shift_enable1, cfg_bit1, set_hard1, busy1, done1;

  always #5 clk = ~clk;

  config_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_enable(shift_enable), .cfg_bit(cfg_bit), .set_hard(set_hard),
    .busy(busy), .done(done)
  );

  config_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .shift_enable(shift_enable1), .cfg_bit(cfg_bit1), .set_hard(set_hard1),
    .busy(busy1), .done(done1)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_q[$];
  int   shifts, seq, set_cnt, done_cnt, pushed;
  logic prev_set = 1'b0;
  logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hF9};

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock, then sample #1 after the edge and score the main DUT.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    if (shift_enable) begin
      check_b("shift_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_b("cfg_bit", cfg_bit, e);
      end
      if (shifts < 32) seq[shifts] = cfg_bit;
      shifts++;
    end else begin
      check_b("cfg_bit_idle_zero", cfg_bit, 1'b0);
    end
    if (set_hard) set_cnt++;
    if (done) begin
      done_cnt++;
      check_b("done_after_set", prev_set, 1'b1);
      check_b("busy_low_at_done", busy, 1'b0);
    end
    prev_set = set_hard;
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
      if (pushed < 20) begin
        exp_q.push_back(w[b]);
        pushed++;
      end
    end
  endtask

  task automatic run_load(input int gap, input int abort_at, input bit start_busy);
    int  guard;
    bit  aborted;
    shifts = 0; seq = 0; set_cnt = 0; done_cnt = 0; pushed = 0; aborted = 0;
    exp_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check_b("busy_after_start", busy, 1'b1);
    check_b("ready_after_start", in_ready, 1'b1);
    for (int w = 0; w < 3; w++) begin
      guard = 0;
      while (!in_ready && !aborted && guard < 100) begin
        step();
        guard++;
        if (abort_at != 0 && shifts == abort_at && shift_enable) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          aborted = 1;
          check_b("busy_after_abort", busy, 1'b0);
          check_b("shift_after_abort", shift_enable, 1'b0);
        end
      end
      if (aborted) break;
      check_b("ready_wait", in_ready, 1'b1);
      if (w == 1 && gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (start_busy && g == 2) start = 1'b1;
          step();
          start = 1'b0;
          check_b("gap_ready", in_ready, 1'b1);
          check_b("gap_no_shift", shift_enable, 1'b0);
          check_b("gap_busy", busy, 1'b1);
        end
      end
      in_valid = 1'b1;
      in_data  = words[w];
      push_word(words[w]);
      step();
      check_b("ready_drops", in_ready, 1'b0);
    end
    if (aborted) begin
      in_valid = 1'b0;
      repeat (25) step();
      check_i("abort_no_set", set_cnt, 0);
      check_i("abort_no_done", done_cnt, 0);
      check_b("abort_idle_busy", busy, 1'b0);
      exp_q.delete();
    end else begin
      guard = 0;
      while (set_cnt == 0 && guard < 50) begin
        step();
        guard++;
      end
      check_i("set_hard_seen", set_cnt, 1);
      check_b("set_no_shift", shift_enable, 1'b0);
      step();
      check_b("done_pulse", done, 1'b1);
      step();
      check_b("done_clears", done, 1'b0);
      in_valid = 1'b0;
      check_i("shift_count", shifts, 20);
      check_i("bit_sequence", seq, 32'h93CA5);
      check_i("queue_drained", exp_q.size(), 0);
      check_i("set_once", set_cnt, 1);
      check_i("done_once", done_cnt, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, cnt1, seq1, set1, ready_again;

    // reset state
    step();
    step();
    check_b("rst_in_ready", in_ready, 1'b0);
    check_b("rst_shift_en", shift_enable, 1'b0);
    check_b("rst_cfg_bit", cfg_bit, 1'b0);
    check_b("rst_set_hard", set_hard, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_done", done, 1'b0);
    rst = 1'b1;
    step();

    // full load, in_valid held high
    run_load(0, 0, 1'b0);
    step();
    // stalled host plus ignored start during the stall
    run_load(5, 0, 1'b1);
    step();
    // abort at the 10th shift, then reload from bit 0
    run_load(0, 10, 1'b0);
    run_load(0, 0, 1'b0);

    // abort coincident with a transfer drops the word
    start = 1'b1;
    step();
    start = 1'b0;
    check_b("ready_before_drop", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_b("drop_busy", busy, 1'b0);
    check_b("drop_ready", in_ready, 1'b0);
    check_b("drop_shift", shift_enable, 1'b0);
    shifts = 0;
    repeat (12) step();
    check_i("drop_shift_count", shifts, 0);

    // asynchronous reset in the middle of SHIFT
    start = 1'b1;
    step();
    start = 1'b0;
    pushed = 0;
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    push_word(8'hA5);
    step();
    in_valid = 1'b0;
    step();
    check_b("shifting_before_rst", shift_enable, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_b("async_rst_shift", shift_enable, 1'b0);
    check_b("async_rst_busy", busy, 1'b0);
    check_b("async_rst_ready", in_ready, 1'b0);
    check_b("async_rst_set", set_hard, 1'b0);
    check_b("async_rst_done", done, 1'b0);
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    step();
    run_load(0, 0, 1'b0);

    // single-word chain
    cnt1 = 0; seq1 = 0; set1 = 0; ready_again = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check_b("one_word_ready", in_ready1, 1'b1);
    in_valid1 = 1'b1;
    in_data1  = 8'h5B;
    step();
    in_valid1 = 1'b0;
    guard = 0;
    while (set1 == 0 && guard < 30) begin
      if (shift_enable1) begin
        seq1[cnt1] = cfg_bit1;
        cnt1++;
      end
      if (in_ready1) ready_again++;
      step();
      guard++;
      if (set_hard1) set1++;
    end
    check_i("one_word_shifts", cnt1, 8);
    check_i("one_word_bits", seq1, 32'h5B);
    check_i("one_word_set", set1, 1);
    check_i("one_word_no_reload", ready_again, 0);
    step();
    check_b("one_word_done", done1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8: width of each configuration word accepted from the host side.
REQ-002 SHALL have parameter CHAIN_LEN, default 20: total bits in the downstream config tile shift chain, from 1 to 65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a valid word.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 SHALL have port in_data, input, WORD_W bits: configuration word, shifted LSB first.
REQ-010 SHALL have port shift_enable, output, 1 bit: drives the tile chain's shift_enable.
REQ-011 SHALL have port cfg_bit, output, 1 bit: drives the tile chain's shift_in_hard.
REQ-012 SHALL have port set_hard, output, 1 bit: drives the tile chain's set_hard.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on completion of a load.

Function
REQ-015 SHALL implement exactly four states:
- IDLE
- LOAD (waiting for a word)
- SHIFT (serialising the held word)
- SET (one-cycle commit)
REQ-016 SHALL register every output, with no combinational path from any input to any output.
REQ-017 SHALL, in IDLE with start=1, clear the bit counter, assert busy and enter LOAD on the next cycle.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL assert in_ready only while in LOAD.
REQ-020 SHALL treat a cycle with in_valid=1 and in_ready=1 as a transfer, capturing in_data into the word buffer and entering SHIFT on the next cycle.
REQ-021 SHALL, in SHIFT:
- assert shift_enable for exactly one cycle per bit;
- present cfg_bit equal to buffer bit k in that same cycle, k running 0..WORD_W-1;
- increment the 16-bit bit counter once per shifted bit.
REQ-022 SHALL, when word bit WORD_W-1 has been shifted and the counter is still below CHAIN_LEN, return to LOAD; shift_enable SHALL be 0 during LOAD, so the chain holds.
REQ-023 SHALL, when the counter reaches CHAIN_LEN, stop shifting immediately and discard the unshifted bits of the final word; the next state SHALL be SET.
REQ-024 SHALL accept exactly ceil(CHAIN_LEN/WORD_W) words per load.
REQ-025 SHALL, in SET, drive set_hard=1 and shift_enable=0 for exactly one cycle, then enter IDLE.
REQ-026 SHALL pulse done for the single cycle after SET, while busy=0.
REQ-027 SHALL, on abort=1 in LOAD or SHIFT, enter IDLE on the next cycle without asserting set_hard or done.
REQ-028 SHALL give abort priority over a simultaneous transfer; the transferred word is dropped.
REQ-029 SHALL ignore abort in IDLE and in SET; SET always completes.
REQ-030 SHALL drive cfg_bit=0 whenever shift_enable=0.

Reset
REQ-031 SHALL, while rst=0, immediately force:
- state to IDLE;
- in_ready, shift_enable, cfg_bit, set_hard, busy and done to 0;
- bit counter and word buffer to 0.
REQ-032 SHALL, on rst asserted mid-load, leave the chain partially loaded with no set_hard issued; the next load SHALL restart from bit 0.
REQ-033 SHALL require at least one clk edge after rst deassertion before start is sampled.

Verification
REQ-034 SHALL cover a full load: CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xF9 with in_valid held high -> 20 shift_enable cycles; cfg_bit sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1; set_hard pulses once; done pulses the cycle after; 0xF9 bits 4-7 are never shifted.
REQ-035 SHALL cover a stalled host: in_valid low for 5 cycles between words 1 and 2 -> in_ready stays 1, shift_enable stays 0 throughout the gap, and the cfg_bit sequence is identical to REQ-034.
REQ-036 SHALL cover abort: abort at the 10th shift cycle -> no set_hard and no done; busy=0 the following cycle; a new start then reloads from bit 0.
REQ-037 SHALL cover reset mid-load: rst=0 during SHIFT -> all outputs 0 asynchronously, with no clk edge required; after release, a start produces a correct full load.
REQ-038 SHALL cover boundary and priority cases:
- CHAIN_LEN=8, WORD_W=8: exactly one word, 8 shifts, then set_hard;
- start while busy: ignored;
- abort coincident with a transfer: the word is dropped.
